// File: rtl/ring_arb_if.sv
// ---------------------------------------------------------------------------
// ring_arb_if -- requester/resource handshake bundle for ring_arb.
//
// Signals:
//   req  [N-1:0]  level-sensitive request per requester, held until served
//   done          current owner releases the resource
//   gnt  [N-1:0]  one-hot grant, drives the resource mux select; 0 when idle
//   busy          1 while any gnt bit is set
//   tok  [N-1:0]  one-hot ring token, highest priority for the next decision
//   tmo           one-cycle pulse on a forced (timeout) revoke
//
// Modports:
//   master -- requester side: drives req/done, observes the arbiter outputs
//   slave  -- arbiter side: consumes req/done, drives gnt/busy/tok/tmo
// ---------------------------------------------------------------------------
interface ring_arb_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         busy;
  logic [N-1:0] tok;
  logic         tmo;

  modport master (
    output req,
    output done,
    input  gnt,
    input  busy,
    input  tok,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output busy,
    output tok,
    output tmo
  );
endinterface

// File: rtl/ring_arb.sv
// ---------------------------------------------------------------------------
// ring_arb -- round-robin arbiter sharing one resource among N requesters.
//
// Priority is a one-hot ring token. After every release the token moves to
// the position just above the released owner, so each requester is served
// within N grants. Grants are non-preemptive and are always followed by a
// dead cycle (REL) so the resource mux sees break-before-make.
//
// Ports:
//   ck   in   clock, all state updates on the rising edge
//   res  in   asynchronous active-low reset
//   bus  slave modport of ring_arb_if (req, done in; gnt, busy, tok, tmo out)
//
// Parameters:
//   N         number of requesters (2..8)
//   MAX_HOLD  longest grant in cycles before a forced revoke
//
// Optional feature (macro RING_ARB_TIMEOUT_EN):
//   Defined   -> a hold counter revokes a grant after MAX_HOLD OWN cycles and
//                pulses tmo for that one cycle.
//   Undefined -> no counter; tmo is tied 0 and a grant lasts until done or
//                until the owner drops its request.
// ---------------------------------------------------------------------------
module ring_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic       ck,
  input  logic       res,
  ring_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q;
  logic [N-1:0] gnt_q;
  logic [N-1:0] tok_q;
  logic         busy_q;
  logic         tmo_q;

  logic         tok_ok;
  logic [N-1:0] tok_eff;
  logic [N-1:0] req_hi;
  logic [N-1:0] req_src;
  logic [N-1:0] pick_d;
  logic [N-1:0] tok_rot_d;
  logic         own_drop;
  logic         tmo_hit;
  logic         rel;
  logic         tmo_d;

  // An illegal (non-one-hot) token is treated as bit 0 for the scan and is
  // rewritten to bit 0 at the next edge.
  assign tok_ok  = $onehot(tok_q);
  assign tok_eff = tok_ok ? tok_q : ONE_N;

  // Wrap-around scan: requests at or above the token position win; if there
  // are none, the lowest request overall wins. The lowest set bit of the
  // chosen set is isolated with x & -x.
  assign req_hi  = bus.req & ~(tok_eff - ONE_N);
  assign req_src = (req_hi != '0) ? req_hi : bus.req;
  assign pick_d  = req_src & (~req_src + ONE_N);

  // Token lands one position above the released owner, wrapping N-1 -> 0.
  assign tok_rot_d = {gnt_q[N-2:0], gnt_q[N-1]};

  // An owner dropping its own request is an implicit done.
  assign own_drop = ~|(bus.req & gnt_q);

`ifdef RING_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_d is the number of OWN cycles completed at this edge; revoking when
  // it reaches MAX_HOLD gives a grant of exactly MAX_HOLD cycles.
  assign cnt_d   = cnt_q + CW'(1);
  assign tmo_hit = (cnt_d == CW'(MAX_HOLD));
`else
  assign tmo_hit = 1'b0;
`endif

  assign rel   = bus.done | own_drop | tmo_hit;
  assign tmo_d = tmo_hit & ~bus.done & ~own_drop;

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tok_q   <= ONE_N;
      tmo_q   <= 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      tmo_q <= 1'b0;
      if (!tok_ok) begin
        tok_q <= ONE_N;
      end
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            gnt_q   <= pick_d;
            busy_q  <= 1'b1;
            state_q <= OWN;
`ifdef RING_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        OWN: begin
          if (rel) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tok_q   <= tok_rot_d;
            tmo_q   <= tmo_d;
            state_q <= REL;
          end
`ifdef RING_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_d;
          end
`endif
        end
        REL: begin
          // Dead cycle: resource mux sees gnt=0 before the next owner.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.tok  = tok_q;
  assign bus.tmo  = tmo_q;

endmodule

// File: doc/ring_arb.md
Name: ring_arb

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority is held as a one-hot ring token, in the same style as the team's ring counter.
- The token rotates one position past the last owner after each release, so every requester is served within N grants.
- Sits between requester blocks and a shared datapath resource (bus or ALU port); its one-hot grant drives the resource mux select directly.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 15, maximum grant length in cycles before a forced revoke (only used with RING_ARB_TIMEOUT_EN).

Ports:
- ck, input, 1, clock; all state updates on rising edge.
- res, input, 1, asynchronous active-low reset.
- req, input, N, request per requester; level-sensitive; held until served.
- done, input, 1, current owner releases the resource; sampled only while busy=1.
- gnt, output, N, registered one-hot grant; all zero when idle.
- busy, output, 1, registered; 1 while any gnt bit is set.
- tok, output, N, registered one-hot ring token; the highest-priority requester for the next decision.
- tmo, output, 1, one-cycle pulse on forced revoke (RING_ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (res=0, asynchronous):
  - gnt=0, busy=0, tmo=0, tok=1 (bit 0), state=IDLE, hold counter=0.
  - Release of res takes effect at the next ck edge.
- States: IDLE, OWN, REL.
- IDLE:
  - If req!=0, select the first set req bit scanning from the tok position upward, wrapping modulo N.
  - Set gnt to that bit at the next edge; busy=1; go to OWN.
  - Latency: req asserted before edge k gives gnt at edge k.
  - If req=0, stay in IDLE; gnt=0.
- OWN:
  - gnt is held stable.
  - Release condition (any of):
    - done=1.
    - The owner's req bit drops to 0; treated as an implicit done.
    - The hold counter reaches MAX_HOLD (timeout, RING_ARB_TIMEOUT_EN only).
  - On release at edge k:
    - gnt=0 and busy=0 at edge k.
    - tok rotates to the bit one position above the released owner, with wrap (owner bit N-1 gives tok=bit 0).
    - Go to REL.
  - Requests from other requesters during OWN are ignored; the grant is not preemptive.
- REL:
  - One mandatory dead cycle with gnt=0; it guarantees break-before-make on the resource mux.
  - Go to IDLE unconditionally.
  - Arbitration in the following IDLE cycle uses the new tok.
- Minimum grant length is 1 cycle; done in the first OWN cycle is honoured.
- Back-to-back spacing: release edge, then REL, then new gnt at the IDLE edge; 2 cycles of gnt=0 between owners.
- Only tok changes ring position; tok is always exactly one-hot.
- Any non-one-hot tok value (illegal) is corrected to bit 0 on the next edge.
- Requester set of N=1 bits (only the owner) still rotates tok; the owner is re-granted after REL+IDLE.
- done while IDLE or REL is ignored.
- Reset asserted mid-OWN: gnt drops immediately (asynchronously); tok returns to bit 0.

Optional Feature:
- Macro: RING_ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter of width clog2(MAX_HOLD+1) clears on entry to OWN and increments each OWN cycle.
  - When the counter equals MAX_HOLD and no other release condition is true, the grant is revoked at that edge.
  - tmo=1 for exactly that cycle; rotation and REL behave as for a normal release.
- Without the macro: no counter is present, tmo is constant 0, and a grant is held indefinitely until done or req drop.

Test Plan:
1. Reset hold then release, req=0000 for 5 cycles -> gnt=0000, busy=0, tok=0001 throughout.
2. req=1111 constant, done pulsed each cycle the arbiter is in OWN -> grant order 0001,0010,0100,1000,0001; tok after each release 0010,0100,1000,0001.
3. tok=0100 with req=0011 -> gnt=0001 (wrap scan); after done, tok=0010 and next gnt=0010.
4. Owner 0010 drops req without done -> gnt=0000 at that edge, tok=0100, no tmo.
5. RING_ARB_TIMEOUT_EN, MAX_HOLD=3, req=0001 held, done=0 -> gnt high for 3 OWN cycles, tmo=1 for one cycle, 2 cycles of gnt=0, then gnt=0001 again; without the macro gnt stays 0001 for 20+ cycles.
6. res driven low mid-OWN between edges -> gnt=0000 and tok=0001 immediately; first grant after release follows the rules of scenario 2.
